// File: rtl/pc_redirect_unit.sv
// Purpose : owns the architectural fetch PC and redirects it on taken branches, flushing fetch/decode.
// Latency : 1 cycle from branch select or fetch accept to the updated pc_out; all outputs registered.
// Backpres: pc_out holds while fetch_ready_in is low; a redirect replaces the pending address regardless.
//
// Ports:
//   clk_in, rst_n_in           core clock (rising edge), async active-low reset
//   branch_valid_in            qualifies pc_mux_sel_in / branch_target_in
//   pc_mux_sel_in [1:0]        01 = take target, anything else = sequential
//   branch_target_in [DW-1:0]  branch target (low two bits ignored)
//   fetch_ready_in             instruction memory accepts pc_out this cycle
//   pc_out, pc_valid_out       fetch request
//   redirect_out               one-cycle pulse after a redirect
//   flush_out                  kill wrong-path work, held FLUSH_DEPTH cycles
//   branch_count_out, taken_count_out  (only with CORE101_BRANCH_PERF_EN defined)
//
// Optional macro: CORE101_BRANCH_PERF_EN adds saturating branch/taken counters.
module pc_redirect_unit #(
   parameter int unsigned            DATA_WIDTH   = 32,
   parameter logic [DATA_WIDTH-1:0]  RESET_VECTOR = '0,
   parameter int unsigned            FLUSH_DEPTH  = 2
) (
   input  logic                  clk_in,
   input  logic                  rst_n_in,
   input  logic                  branch_valid_in,
   input  logic [1:0]            pc_mux_sel_in,
   input  logic [DATA_WIDTH-1:0] branch_target_in,
   input  logic                  fetch_ready_in,
   output logic [DATA_WIDTH-1:0] pc_out,
   output logic                  pc_valid_out,
   output logic                  redirect_out,
`ifdef CORE101_BRANCH_PERF_EN
   output logic [31:0]           branch_count_out,
   output logic [31:0]           taken_count_out,
`endif
   output logic                  flush_out
);

   typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_t;

   localparam logic [3:0]            CNT_INIT = 4'(FLUSH_DEPTH - 1);
   localparam logic [DATA_WIDTH-1:0] PC_STEP  = DATA_WIDTH'(4);

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] pc_q, pc_d;
   logic [3:0]            cnt_q, cnt_d;
   logic                  valid_q, valid_d;
   logic                  redirect_q, redirect_d;
   logic                  flush_q, flush_d;

   logic accept;
   logic taken;

   assign accept = valid_q && fetch_ready_in;
   assign taken  = branch_valid_in && (pc_mux_sel_in == 2'b01);

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      cnt_d      = cnt_q;
      valid_d    = valid_q;
      redirect_d = 1'b0;
      flush_d    = flush_q;
      case (state_q)
         BOOT: begin
            // First request after reset presents RESET_VECTOR unchanged.
            state_d = RUN;
            valid_d = 1'b1;
         end
         RUN: begin
            if (taken) begin
               // Redirect wins over the increment; the in-flight address is dropped.
               pc_d       = {branch_target_in[DATA_WIDTH-1:2], 2'b00};
               redirect_d = 1'b1;
               flush_d    = 1'b1;
               cnt_d      = CNT_INIT;
               state_d    = FLUSH;
            end else if (accept) begin
               pc_d = pc_q + PC_STEP;
            end
         end
         FLUSH: begin
            // Branch inputs here come from wrong-path instructions and are ignored.
            if (accept) begin
               pc_d = pc_q + PC_STEP;
            end
            if (cnt_q == 4'd0) begin
               state_d = RUN;
               flush_d = 1'b0;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: begin
            state_d = BOOT;
            valid_d = 1'b0;
            flush_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q    <= BOOT;
         pc_q       <= RESET_VECTOR;
         cnt_q      <= 4'd0;
         valid_q    <= 1'b0;
         redirect_q <= 1'b0;
         flush_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         cnt_q      <= cnt_d;
         valid_q    <= valid_d;
         redirect_q <= redirect_d;
         flush_q    <= flush_d;
      end
   end

   assign pc_out       = pc_q;
   assign pc_valid_out = valid_q;
   assign redirect_out = redirect_q;
   assign flush_out    = flush_q;

`ifdef CORE101_BRANCH_PERF_EN
   logic [31:0] bcnt_q, bcnt_d;
   logic [31:0] tcnt_q, tcnt_d;

   // Only branches observed in RUN are counted; both counters saturate.
   always_comb begin
      bcnt_d = bcnt_q;
      tcnt_d = tcnt_q;
      if (state_q == RUN) begin
         if (branch_valid_in && (bcnt_q != 32'hFFFF_FFFF)) bcnt_d = bcnt_q + 32'd1;
         if (taken && (tcnt_q != 32'hFFFF_FFFF))           tcnt_d = tcnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         bcnt_q <= 32'd0;
         tcnt_q <= 32'd0;
      end else begin
         bcnt_q <= bcnt_d;
         tcnt_q <= tcnt_d;
      end
   end

   assign branch_count_out = bcnt_q;
   assign taken_count_out  = tcnt_q;
`endif

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Purpose : self-checking bench for pc_redirect_unit (DATA_WIDTH 32, RESET_VECTOR 0, FLUSH_DEPTH 2).
// Latency : each vector is applied before a rising edge and its outputs are checked at the next falling edge.
// Backpres: fetch_ready_in is driven from the vector table to exercise stalls.
module tb_pc_redirect_unit;

   logic        clk_in;
   logic        rst_n_in;
   logic        branch_valid_in;
   logic [1:0]  pc_mux_sel_in;
   logic [31:0] branch_target_in;
   logic        fetch_ready_in;
   logic [31:0] pc_out;
   logic        pc_valid_out;
   logic        redirect_out;
   logic        flush_out;
`ifdef CORE101_BRANCH_PERF_EN
   logic [31:0] branch_count_out;
   logic [31:0] taken_count_out;
`endif

   pc_redirect_unit #(
      .DATA_WIDTH  (32),
      .RESET_VECTOR(32'h0000_0000),
      .FLUSH_DEPTH (2)
   ) dut (
      .clk_in          (clk_in),
      .rst_n_in        (rst_n_in),
      .branch_valid_in (branch_valid_in),
      .pc_mux_sel_in   (pc_mux_sel_in),
      .branch_target_in(branch_target_in),
      .fetch_ready_in  (fetch_ready_in),
      .pc_out          (pc_out),
      .pc_valid_out    (pc_valid_out),
      .redirect_out    (redirect_out),
`ifdef CORE101_BRANCH_PERF_EN
      .branch_count_out(branch_count_out),
      .taken_count_out (taken_count_out),
`endif
      .flush_out       (flush_out)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   typedef struct {
      logic        rdy;
      logic        bv;
      logic [1:0]  sel;
      logic [31:0] tgt;
      logic [31:0] pc;
      logic        vld;
      logic        redir;
      logic        flush;
   } vec_t;

   typedef struct {
      logic [31:0] pc;
      logic        vld;
      logic        redir;
      logic        flush;
   } exp_t;

   localparam int NV = 26;
   vec_t vecs[NV];
   exp_t sb_q[$];

   int total;
   int bad;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s act=%h req=%h", nm, act, req);
      end
   endtask

   function automatic vec_t mk(input logic rdy, input logic bv, input logic [1:0] sel,
                               input logic [31:0] tgt, input logic [31:0] pc,
                               input logic vld, input logic redir, input logic flush);
      vec_t v;
      v.rdy = rdy; v.bv = bv; v.sel = sel; v.tgt = tgt;
      v.pc = pc; v.vld = vld; v.redir = redir; v.flush = flush;
      return v;
   endfunction

   task automatic check_outputs(input string tag, input exp_t e);
      chk({tag, " pc"},    pc_out,       e.pc);
      chk({tag, " vld"},   {31'd0, pc_valid_out}, {31'd0, e.vld});
      chk({tag, " redir"}, {31'd0, redirect_out}, {31'd0, e.redir});
      chk({tag, " flush"}, {31'd0, flush_out},    {31'd0, e.flush});
   endtask

   initial begin
      exp_t e;
      total = 0;
      bad   = 0;

      //            rdy  bv   sel    target          pc              vld  rd   fl
      vecs[0]  = mk(1'b1, 1'b0, 2'b00, 32'h0,         32'h0000_0000, 1'b1, 1'b0, 1'b0); // BOOT -> RUN, RESET_VECTOR
      vecs[1]  = mk(1'b1, 1'b0, 2'b00, 32'h0,         32'h0000_0004, 1'b1, 1'b0, 1'b0);
      vecs[2]  = mk(1'b1, 1'b0, 2'b00, 32'h0,         32'h0000_0008, 1'b1, 1'b0, 1'b0);
      vecs[3]  = mk(1'b1, 1'b0, 2'b00, 32'h0,         32'h0000_000C, 1'b1, 1'b0, 1'b0);
      vecs[4]  = mk(1'b1, 1'b0, 2'b00, 32'h0,         32'h0000_0010, 1'b1, 1'b0, 1'b0);
      vecs[5]  = mk(1'b0, 1'b0, 2'b00, 32'h0,         32'h0000_0010, 1'b1, 1'b0, 1'b0); // stall x3
      vecs[6]  = mk(1'b0, 1'b0, 2'b00, 32'h0,         32'h0000_0010, 1'b1, 1'b0, 1'b0);
      vecs[7]  = mk(1'b0, 1'b0, 2'b00, 32'h0,         32'h0000_0010, 1'b1, 1'b0, 1'b0);
      vecs[8]  = mk(1'b1, 1'b0, 2'b00, 32'h0,         32'h0000_0014, 1'b1, 1'b0, 1'b0);
      vecs[9]  = mk(1'b0, 1'b1, 2'b01, 32'h0000_0103, 32'h0000_0100, 1'b1, 1'b1, 1'b1); // redirect, align
      vecs[10] = mk(1'b0, 1'b0, 2'b00, 32'h0,         32'h0000_0100, 1'b1, 1'b0, 1'b1);
      vecs[11] = mk(1'b0, 1'b0, 2'b00, 32'h0,         32'h0000_0100, 1'b1, 1'b0, 1'b0); // flush was 2 cycles
      vecs[12] = mk(1'b0, 1'b1, 2'b10, 32'h0000_0300, 32'h0000_0100, 1'b1, 1'b0, 1'b0); // sel 10: no redirect
      vecs[13] = mk(1'b1, 1'b1, 2'b01, 32'h0000_0100, 32'h0000_0100, 1'b1, 1'b1, 1'b1); // redirect beats accept
      vecs[14] = mk(1'b1, 1'b1, 2'b01, 32'h0000_0200, 32'h0000_0104, 1'b1, 1'b0, 1'b1); // ignored in FLUSH
      vecs[15] = mk(1'b1, 1'b1, 2'b01, 32'h0000_0200, 32'h0000_0108, 1'b1, 1'b0, 1'b0); // ignored on exit cycle
      vecs[16] = mk(1'b1, 1'b0, 2'b00, 32'h0,         32'h0000_010C, 1'b1, 1'b0, 1'b0);
      vecs[17] = mk(1'b1, 1'b1, 2'b11, 32'h0000_0500, 32'h0000_0110, 1'b1, 1'b0, 1'b0); // sel 11
      vecs[18] = mk(1'b1, 1'b1, 2'b00, 32'h0000_0500, 32'h0000_0114, 1'b1, 1'b0, 1'b0); // sel 00
      vecs[19] = mk(1'b1, 1'b0, 2'b01, 32'h0000_0500, 32'h0000_0118, 1'b1, 1'b0, 1'b0); // not valid
      vecs[20] = mk(1'b0, 1'b1, 2'b01, 32'hFFFF_FFFE, 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b1);
      vecs[21] = mk(1'b1, 1'b0, 2'b00, 32'h0,         32'h0000_0000, 1'b1, 1'b0, 1'b1); // wrap to 0
      vecs[22] = mk(1'b1, 1'b0, 2'b00, 32'h0,         32'h0000_0004, 1'b1, 1'b0, 1'b0);
      vecs[23] = mk(1'b1, 1'b1, 2'b01, 32'h0000_0040, 32'h0000_0040, 1'b1, 1'b1, 1'b1); // first RUN cycle honoured
      vecs[24] = mk(1'b1, 1'b0, 2'b00, 32'h0,         32'h0000_0044, 1'b1, 1'b0, 1'b1);
      vecs[25] = mk(1'b0, 1'b0, 2'b00, 32'h0,         32'h0000_0044, 1'b1, 1'b0, 1'b0);

      rst_n_in         = 1'b0;
      branch_valid_in  = 1'b0;
      pc_mux_sel_in    = 2'b00;
      branch_target_in = 32'h0;
      fetch_ready_in   = 1'b1;

      repeat (3) @(negedge clk_in);
      e = '{pc: 32'h0, vld: 1'b0, redir: 1'b0, flush: 1'b0};
      check_outputs("reset", e);

      rst_n_in = 1'b1;
      #1;
      check_outputs("boot", e);

      for (int i = 0; i < NV; i++) begin
         fetch_ready_in   = vecs[i].rdy;
         branch_valid_in  = vecs[i].bv;
         pc_mux_sel_in    = vecs[i].sel;
         branch_target_in = vecs[i].tgt;
         sb_q.push_back('{pc: vecs[i].pc, vld: vecs[i].vld, redir: vecs[i].redir, flush: vecs[i].flush});
         @(negedge clk_in);
         if (sb_q.size() == 0) begin
            total++; bad++;
            $display("FAIL v%0d scoreboard empty", i);
         end else begin
            e = sb_q.pop_front();
            check_outputs($sformatf("v%0d", i), e);
         end
      end

`ifdef CORE101_BRANCH_PERF_EN
      // RUN-state branches: v9,v12,v13,v17,v18,v20,v23; taken: v9,v13,v20,v23.
      chk("branch_count", branch_count_out, 32'd7);
      chk("taken_count",  taken_count_out,  32'd4);
`endif

      // Asynchronous reset in the middle of a flush.
      fetch_ready_in   = 1'b1;
      branch_valid_in  = 1'b1;
      pc_mux_sel_in    = 2'b01;
      branch_target_in = 32'h0000_0880;
      @(negedge clk_in);
      branch_valid_in = 1'b0;
      e = '{pc: 32'h0000_0880, vld: 1'b1, redir: 1'b1, flush: 1'b1};
      check_outputs("preflush", e);
      #2;
      rst_n_in = 1'b0;
      #1;
      e = '{pc: 32'h0, vld: 1'b0, redir: 1'b0, flush: 1'b0};
      check_outputs("async_rst", e);
`ifdef CORE101_BRANCH_PERF_EN
      chk("branch_count_rst", branch_count_out, 32'd0);
      chk("taken_count_rst",  taken_count_out,  32'd0);
`endif
      @(negedge clk_in);
      rst_n_in = 1'b1;
      @(negedge clk_in);
      // Pending flush is gone: first request after reset is RESET_VECTOR, no flush.
      e = '{pc: 32'h0, vld: 1'b1, redir: 1'b0, flush: 1'b0};
      check_outputs("post_rst", e);
      @(negedge clk_in);
      e = '{pc: 32'h4, vld: 1'b1, redir: 1'b0, flush: 1'b0};
      check_outputs("post_rst2", e);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
